serial_echo_fifo: RTL and testbench

- Parametrised successor to the single-byte RX→TX echo controller.
- Sits between the UART receiver and transmitter. Detects each completed RX word from the receiver's status line and applies a selectable per-word transform.
- Buffers transformed words in a DEPTH-entry FIFO and drains them to the transmitter with a TX_EN pulse and status handshake.
- Adds word-width generality, burst buffering, mode select, overflow and handshake-timeout reporting.

---
 rtl/serial_echo_fifo_if.sv | 27 ++
 rtl/serial_echo_fifo.sv | 148 ++++++++++++++
 tb/tb_serial_echo_fifo.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_echo_fifo_if.sv
// Signal bundle between the UART-facing environment and the echo FIFO block.
// Signal names follow the receiver/transmitter datasheet names.
interface serial_echo_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic [DATA_W-1:0]      RX_DATA;
  logic                   RX_STATUS;
  logic [1:0]             MODE;
  logic                   TX_STATUS;
  logic                   CLR_ERR;
  logic [DATA_W-1:0]      TX_DATA;
  logic                   TX_EN;
  logic [$clog2(DEPTH):0] FILL;
  logic                   OVERFLOW;
  logic                   TX_TIMEOUT;

  modport master (
    output RX_DATA, RX_STATUS, MODE, TX_STATUS, CLR_ERR,
    input  TX_DATA, TX_EN, FILL, OVERFLOW, TX_TIMEOUT
  );

  modport slave (
    input  RX_DATA, RX_STATUS, MODE, TX_STATUS, CLR_ERR,
    output TX_DATA, TX_EN, FILL, OVERFLOW, TX_TIMEOUT
  );
endinterface

// File: rtl/serial_echo_fifo.sv
// UART RX->TX echo: detects completed RX words, transforms them, buffers them
// in a circular FIFO and drains them to the transmitter with a strobe/ack handshake.
module serial_echo_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_echo_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  // Transform selected by MODE; L = low DATA_W-1 bits, M = MSB.
  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d,
                                               input logic [1:0]        m);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      2'd1:    if (d[DATA_W-1]) r = {1'b1, ~d[DATA_W-2:0]};
      2'd2:    r = {d[DATA_W-1], ~d[DATA_W-2:0]};
      2'd3:    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      default: r = d;
    endcase
    return r;
  endfunction

  // ---------------- RX status synchroniser and fall detect ----------------
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_hist;
  logic                   rx_fall;

  // Preset to 1 so that releasing reset with RX_STATUS idle-high is not a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '1;
      rx_hist <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values, which is what makes the shift chain a chain.
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], bus.RX_STATUS};
      rx_hist <= rx_sync[SYNC_STAGES-1];
    end
  end

  assign rx_fall = rx_hist & ~rx_sync[SYNC_STAGES-1];

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fill;
  logic              full, push_ok, pop, overflow_evt;

  assign full         = (fill == (AW+1)'(DEPTH));
  assign push_ok      = rx_fall & (~full | pop);
  assign overflow_evt = rx_fall & full & ~pop;

  // NOTE: the storage array has no reset; it is never read before being
  // written because FILL gates every pop, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= xform(bus.RX_DATA, bus.MODE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // ---------------- TX handshake FSM ----------------
  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              timeout_evt;
  logic [DATA_W-1:0] tx_data;
  logic              tx_en, overflow, tx_timeout;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pop         = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      IDLE: begin
        // FILL is registered, so a word pushed this edge cannot pop until the next.
        if (fill != '0 && bus.TX_STATUS) begin
          pop      = 1'b1;
          cnt_nx   = '0;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!bus.TX_STATUS) begin
          state_nx = WAIT_DONE;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_nx    = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_DONE: if (bus.TX_STATUS) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      overflow   <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tx_en <= pop;
      if (pop) tx_data <= mem[rd_ptr];
      // A new error event takes priority over a simultaneous clear.
      if (overflow_evt)     overflow <= 1'b1;
      else if (bus.CLR_ERR) overflow <= 1'b0;
      if (timeout_evt)      tx_timeout <= 1'b1;
      else if (bus.CLR_ERR) tx_timeout <= 1'b0;
    end
  end

  assign bus.TX_DATA    = tx_data;
  assign bus.TX_EN      = tx_en;
  assign bus.FILL       = fill;
  assign bus.OVERFLOW   = overflow;
  assign bus.TX_TIMEOUT = tx_timeout;
endmodule

// File: tb/tb_serial_echo_fifo.sv
// Self-checking bench for serial_echo_fifo: vector table for the transforms,
// scoreboard on every TX_EN, and hand sequences for overflow, timeout and reset.
module tb_serial_echo_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_echo_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  serial_echo_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2), .ACK_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  int         checks = 0, failures = 0;
  int         cyc = 0, en_count = 0, last_en_cyc = -1, send_cyc = 0;
  logic [7:0] sb[$];
  bit         tx_emulate = 1'b0;
  logic       tx_level   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] m);
    logic [7:0] r;
    case (m)
      2'd0: r = d;
      2'd1: r = d[7] ? {1'b1, ~d[6:0]} : d;
      2'd2: r = {d[7], ~d[6:0]};
      default: for (int i = 0; i < 8; i++) r[i] = d[7-i];
    endcase
    return r;
  endfunction

  // Advance to the next falling edge and score any TX strobe seen there.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (bus.TX_EN === 1'b1) begin
      en_count++;
      last_en_cyc = cyc;
      if (sb.size() == 0) check("unexpected_tx_en_queue_size", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("tx_data_scoreboard", bus.TX_DATA, e);
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] m,
                      input logic [7:0] exp, input bit expect_out);
    bus.RX_DATA   = d;
    bus.MODE      = m;
    bus.RX_STATUS = 1'b0;
    send_cyc      = cyc;
    if (expect_out) sb.push_back(exp);
    repeat (4) tick();
    bus.RX_STATUS = 1'b1;
    repeat (3) tick();
  endtask

  // Transmitter: either a forced level, or an emulation that goes busy for
  // three cycles after each TX_EN strobe.
  initial begin
    int busy;
    busy = 0;
    bus.TX_STATUS = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!tx_emulate) begin
        bus.TX_STATUS = tx_level;
        busy = 0;
      end else begin
        if (bus.TX_EN === 1'b1) busy = 3;
        if (busy > 0) begin
          bus.TX_STATUS = 1'b0;
          busy--;
        end else begin
          bus.TX_STATUS = 1'b1;
        end
      end
    end
  end

  initial begin
    vec_t vecs[7];
    int   en0, n;
    logic [7:0] d;
    logic [1:0] m;

    vecs[0] = '{8'hA5, 2'd1, 8'hDA};
    vecs[1] = '{8'h25, 2'd1, 8'h25};
    vecs[2] = '{8'h81, 2'd0, 8'h81};
    vecs[3] = '{8'h81, 2'd2, 8'hFE};
    vecs[4] = '{8'h81, 2'd3, 8'h81};
    vecs[5] = '{8'h01, 2'd3, 8'h80};
    vecs[6] = '{8'h3C, 2'd2, 8'h43};

    bus.RX_DATA   = '0;
    bus.RX_STATUS = 1'b1;
    bus.MODE      = 2'd0;
    bus.CLR_ERR   = 1'b0;

    // 1: reset state and quiet idle period
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_tx_data", bus.TX_DATA, 0);
    check("reset_fill", bus.FILL, 0);
    check("reset_flags", {bus.OVERFLOW, bus.TX_TIMEOUT, bus.TX_EN}, 0);
    repeat (100) tick();
    check("idle_no_tx_en", en_count, 0);
    check("idle_fill", bus.FILL, 0);

    // 2/3: transform table with latency and single-cycle strobe
    tx_emulate = 1'b1;
    foreach (vecs[i]) begin
      en0 = en_count;
      send(vecs[i].data, vecs[i].mode, vecs[i].exp, 1'b1);
      check($sformatf("latency_vec%0d", i), last_en_cyc - send_cyc, 4);
      repeat (3) tick();
      check($sformatf("tx_en_once_vec%0d", i), en_count - en0, 1);
      check($sformatf("tx_data_hold_vec%0d", i), bus.TX_DATA, vecs[i].exp);
    end

    // 4: overflow with transmitter busy, then drain in order
    tx_emulate = 1'b0;
    tx_level   = 1'b0;
    repeat (2) tick();
    en0 = en_count;
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 37 + 5);
      m = 2'(i % 4);
      send(d, m, model(d, m), i < 16);
      if (i == 0)  check("fill_after_first", bus.FILL, 1);
      if (i == 15) check("no_overflow_at_full", bus.OVERFLOW, 0);
    end
    check("fill_full", bus.FILL, 16);
    check("overflow_set", bus.OVERFLOW, 1);
    check("no_tx_while_busy", en_count - en0, 0);
    tx_emulate = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
    repeat (8) tick();
    check("drain_count", en_count - en0, 16);
    check("drain_fill", bus.FILL, 0);
    check("overflow_sticky", bus.OVERFLOW, 1);
    bus.CLR_ERR = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0;
    check("overflow_cleared", bus.OVERFLOW, 0);

    // 5: transmitter never acknowledges
    tx_emulate = 1'b0;
    tx_level   = 1'b1;
    repeat (2) tick();
    en0 = en_count;
    send(8'h5A, 2'd0, 8'h5A, 1'b1);
    repeat (50) tick();
    check("timeout_not_yet", bus.TX_TIMEOUT, 0);
    repeat (20) tick();
    check("timeout_set", bus.TX_TIMEOUT, 1);
    check("timeout_no_retry", en_count - en0, 1);
    bus.CLR_ERR = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0;
    check("timeout_cleared", bus.TX_TIMEOUT, 0);
    en0 = en_count;
    send(8'hC3, 2'd3, 8'hC3, 1'b1);
    check("idle_after_timeout_latency", last_en_cyc - send_cyc, 4);
    repeat (70) tick();
    check("second_timeout", bus.TX_TIMEOUT, 1);
    check("second_word_once", en_count - en0, 1);
    bus.CLR_ERR = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0;

    // 6: reset while in WAIT_DONE with five words queued
    tx_level = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) begin
      d = 8'(8'h10 + i);
      send(d, 2'd0, d, 1'b1);
    end
    check("prereset_fill6", bus.FILL, 6);
    en0 = en_count;
    tx_level = 1'b1;
    n = 0;
    while (en_count == en0 && n < 10) begin
      tick();
      n++;
    end
    tx_level = 1'b0;
    check("prereset_pop", en_count - en0, 1);
    repeat (4) tick();
    check("prereset_fill5", bus.FILL, 5);
    rst_n = 1'b0;
    #1;
    check("async_reset_fill", bus.FILL, 0);
    check("async_reset_tx_data", bus.TX_DATA, 0);
    check("async_reset_flags", {bus.OVERFLOW, bus.TX_TIMEOUT, bus.TX_EN}, 0);
    sb.delete();
    tx_level = 1'b1;
    en0 = en_count;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("post_reset_no_tx_en", en_count - en0, 0);
    check("post_reset_fill", bus.FILL, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
